// File: rtl/alu_operand_regfile_if.sv
// Issue/write-back bus between the operand register file and its neighbours:
// master drives requests and write-back, slave returns the registered ALU operands.
interface alu_operand_regfile_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [1:0]        op_in;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] ALU_in1;
  logic [DATA_W-1:0] ALU_in2;
  logic [1:0]        op;
  logic              out_valid;

  modport master (
    output rd_en, rd_addr1, rd_addr2, op_in, wr_en, wr_addr, wr_data,
    input  ALU_in1, ALU_in2, op, out_valid
  );

  modport slave (
    input  rd_en, rd_addr1, rd_addr2, op_in, wr_en, wr_addr, wr_data,
    output ALU_in1, ALU_in2, op, out_valid
  );
endinterface

// File: rtl/alu_operand_regfile.sv
// Register file with two forwarded read ports and one write port, launching a
// registered operand pair plus opcode into the ALU one cycle after each issue.
module alu_operand_regfile #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 3,
  parameter int NUM_REGS  = 8,
  parameter int REG0_ZERO = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_operand_regfile_if.slave  bus
);
  localparam int NUM_RD = 2;

  genvar gi;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
  logic [NUM_RD-1:0][ADDR_W-1:0]   rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0]   operand_q;
  logic                            wr_drop;
  logic                            wr_ok;
  logic [1:0]                      op_reg;
  logic                            out_valid_reg;

  assign rd_addr[0] = bus.rd_addr1;
  assign rd_addr[1] = bus.rd_addr2;

  // A write to the hardwired zero register must neither land nor forward.
  assign wr_drop = (REG0_ZERO != 0) && (bus.wr_addr == '0);
  assign wr_ok   = bus.wr_en && !wr_drop;

  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if ((REG0_ZERO != 0) && (gi == 0)) begin : g_zero
        assign regs_q[gi] = '0;
      end else begin : g_flop
        logic [DATA_W-1:0] data_reg;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            data_reg <= '0;
          end else if (wr_ok && (bus.wr_addr == ADDR_W'(gi))) begin
            data_reg <= bus.wr_data;
          end
        end

        assign regs_q[gi] = data_reg;
      end
    end
  endgenerate

  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [DATA_W-1:0] sel_next;
      logic [DATA_W-1:0] sel_reg;

      // Write-through: a same-edge write wins over the stored value; zero wins over both.
      always_comb begin
        sel_next = regs_q[rd_addr[gi]];
        if (wr_ok && (bus.wr_addr == rd_addr[gi])) begin
          sel_next = bus.wr_data;
        end
        if ((REG0_ZERO != 0) && (rd_addr[gi] == '0)) begin
          sel_next = '0;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sel_reg <= '0;
        end else if (bus.rd_en) begin
          sel_reg <= sel_next;
        end
      end

      assign operand_q[gi] = sel_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg        <= 2'b00;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= bus.rd_en;
      if (bus.rd_en) begin
        op_reg <= bus.op_in;
      end
    end
  end

  assign bus.ALU_in1   = operand_q[0];
  assign bus.ALU_in2   = operand_q[1];
  assign bus.op        = op_reg;
  assign bus.out_valid = out_valid_reg;
endmodule
